seg_scan_rx: RTL

Receive-side block for the multiplexed seven-segment display bus. It samples the active-low segment lines and active-low digit enables that the BCD-to-seven-segment decoder and scan driver produce. Each digit's segment pattern is debounced and decoded back to BCD, and the result is held per digit position. It sits on the loop-back and self-test path of the display subsystem, so the bench and the on-chip checker can confirm what the display is actually showing.

---
 rtl/seg_scan_if.sv | 24 ++
 rtl/seg_scan_rx.sv | 132 +++++++++++++
 2 files changed

// File: rtl/seg_scan_if.sv
// Seven-segment loop-back bus: the active-low segment/enable lines seen by the receiver,
// plus the receiver's decoded results.
interface seg_scan_if #(
    parameter int NDIG = 4
);
    logic [6:0]        seg;
    logic [NDIG-1:0]   an;
    logic [4*NDIG-1:0] bcd;
    logic [NDIG-1:0]   dig_valid;
    logic              upd;
    logic [2:0]        upd_idx;
    logic              bad;
    logic [7:0]        err_cnt;

    modport master (
        output seg, an,
        input  bcd, dig_valid, upd, upd_idx, bad, err_cnt
    );

    modport slave (
        input  seg, an,
        output bcd, dig_valid, upd, upd_idx, bad, err_cnt
    );
endinterface

// File: rtl/seg_scan_rx.sv
// Samples a multiplexed seven-segment bus, debounces each digit's pattern over STABLE
// identical samples and decodes it back to BCD, holding the result per digit position.
module seg_scan_rx #(
    parameter int NDIG   = 4,
    parameter int STABLE = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    seg_scan_if.slave  bus
);
    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int PW = NDIG + 7;

    typedef enum logic [1:0] {IDLE, TRACK, HOLD} state_t;

    state_t              state_q;
    logic [3:0]          cnt_q;
    logic [3:0]          cnt_d;
    logic [PW-1:0]       ref_q;
    logic [6:0]          s_seg_q;
    logic [NDIG-1:0]     s_an_q;
    logic [4*NDIG-1:0]   bcd_q;
    logic [NDIG-1:0]     dig_valid_q;
    logic                upd_q;
    logic [2:0]          upd_idx_q;
    logic                bad_q;
    logic [7:0]          err_cnt_q;
    logic [7:0]          err_cnt_d;

    logic [PW-1:0]       pair_c;
    logic [3:0]          nzero_c;
    logic [IW-1:0]       sel_idx_c;
    logic                sel_valid_c;
    logic [4:0]          dec_c;

    // Returns {legal, value}; blank decodes to F, anything unknown is illegal.
    function automatic logic [4:0] seg_decode(input logic [6:0] p);
        case (p)
            7'h40:          seg_decode = {1'b1, 4'h0};
            7'h79:          seg_decode = {1'b1, 4'h1};
            7'h24:          seg_decode = {1'b1, 4'h2};
            7'h30:          seg_decode = {1'b1, 4'h3};
            7'h19:          seg_decode = {1'b1, 4'h4};
            7'h12:          seg_decode = {1'b1, 4'h5};
            7'h02, 7'h03:   seg_decode = {1'b1, 4'h6};
            7'h78:          seg_decode = {1'b1, 4'h7};
            7'h00:          seg_decode = {1'b1, 4'h8};
            7'h10, 7'h18:   seg_decode = {1'b1, 4'h9};
            7'h7F:          seg_decode = {1'b1, 4'hF};
            default:        seg_decode = {1'b0, 4'hF};
        endcase
    endfunction

    // Multiple enables low is treated exactly like no enable at all.
    always_comb begin
        nzero_c   = 4'd0;
        sel_idx_c = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (!s_an_q[i]) begin
                nzero_c   = nzero_c + 4'd1;
                sel_idx_c = IW'(i);
            end
        end
        sel_valid_c = (nzero_c == 4'd1);
    end

    assign pair_c    = {s_an_q, s_seg_q};
    assign dec_c     = seg_decode(s_seg_q);
    assign cnt_d     = cnt_q + 4'd1;
    assign err_cnt_d = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            ref_q       <= '1;
            s_seg_q     <= 7'h7F;
            s_an_q      <= '1;
            bcd_q       <= '1;
            dig_valid_q <= '0;
            upd_q       <= 1'b0;
            upd_idx_q   <= 3'd0;
            bad_q       <= 1'b0;
            err_cnt_q   <= 8'd0;
        end else begin
            s_seg_q <= bus.seg;
            s_an_q  <= bus.an;
            upd_q   <= 1'b0;
            bad_q   <= 1'b0;

            if (state_q == IDLE) begin
                if (sel_valid_c) begin
                    ref_q   <= pair_c;
                    cnt_q   <= 4'd1;
                    state_q <= TRACK;
                end
            end else if (pair_c != ref_q) begin
                // Any change restarts the debounce on the new pair, or drops to idle.
                if (sel_valid_c) begin
                    ref_q   <= pair_c;
                    cnt_q   <= 4'd1;
                    state_q <= TRACK;
                end else begin
                    cnt_q   <= 4'd0;
                    state_q <= IDLE;
                end
            end else if (state_q == TRACK) begin
                cnt_q <= cnt_d;
                if (cnt_d == 4'(STABLE)) begin
                    state_q <= HOLD;
                    if (dec_c[4]) begin
                        bcd_q[4*sel_idx_c +: 4]  <= dec_c[3:0];
                        dig_valid_q[sel_idx_c]   <= 1'b1;
                        upd_q                    <= 1'b1;
                        upd_idx_q                <= 3'(sel_idx_c);
                    end else begin
                        bad_q     <= 1'b1;
                        err_cnt_q <= err_cnt_d;
                    end
                end
            end
        end
    end

    assign bus.bcd       = bcd_q;
    assign bus.dig_valid = dig_valid_q;
    assign bus.upd       = upd_q;
    assign bus.upd_idx   = upd_idx_q;
    assign bus.bad       = bad_q;
    assign bus.err_cnt   = err_cnt_q;

endmodule
